// File: rtl/uart_rx_fifo_if.sv
// Receive-side bundle of the UART receiver: serial line in, FIFO pop port and status out.
// The host side (bench or debug master) uses master; the receiver uses slave.
interface uart_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();
    logic                        rx;
    logic                        rd_en;
    logic [7:0]                  rd_data;
    logic                        empty;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        busy;
    logic                        frame_err;
    logic                        overrun;

    modport master (
        output rx, rd_en,
        input  rd_data, empty, full, count, busy, frame_err, overrun
    );

    modport slave (
        input  rx, rd_en,
        output rd_data, empty, full, count, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// The serial line is double-synchronised; bytes are pushed at the stop-bit sample.
module uart_rx_fifo #(
    parameter int unsigned BIT_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic           HCLK,
    input logic           HRESETn,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned CntW = $clog2(BIT_CYCLES);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] CntHalf   = CntW'(BIT_CYCLES / 2 - 1);
    localparam logic [CntW-1:0] CntLast   = CntW'(BIT_CYCLES - 1);
    localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic            frame_err_q;
    logic            push;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [7:0]      rd_data_q, head_d;
    logic            overrun_q;
    logic            pop_ok, push_ok;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= bus.rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            frame_err_q <= 1'b0;
            cnt_q       <= cnt_q + CntW'(1);
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) state_q <= StStart;
                end
                StStart: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit
                    if (cnt_q == CntHalf) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s_q ? StIdle : StData;
                    end
                end
                StData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) state_q <= StStop;
                        else               idx_q   <= idx_q + 3'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == CntLast) begin
                        cnt_q       <= '0;
                        frame_err_q <= !rx_s_q;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign push = (state_q == StStop) && (cnt_q == CntLast) && rx_s_q;

    always_comb begin
        pop_ok   = bus.rd_en && (count_q != '0);
        // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
        push_ok  = push && ((count_q != CountFull) || pop_ok);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
        count_d  = count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop_ok);
        head_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? shift_q : mem_q[rd_ptr_d];
    end

    always_ff @(posedge HCLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + PtrW'(push_ok);
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= push && !push_ok;
            if ((push_ok || pop_ok) && (count_d != '0)) rd_data_q <= head_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == CountFull);
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomised bench for uart_rx_fifo against a queue-based model of the
// serial framing and FIFO occupancy.
module tb_uart_rx_fifo;
    localparam int unsigned B     = 16;
    localparam int unsigned DEPTH = 16;

    logic HCLK = 1'b0;
    logic HRESETn;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .BIT_CYCLES(B),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_seen  = 0;
    int ov_seen  = 0;
    int fe_exp   = 0;
    int ov_exp   = 0;
    logic [7:0] q[$];

    // Count every cycle a pulse output is high; a stuck pulse inflates the count
    always @(negedge HCLK) begin
        if (bus.frame_err === 1'b1) fe_seen++;
        if (bus.overrun === 1'b1) ov_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fifo(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
        check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
        check({tag, "_full"}, 32'(bus.full), 32'(q.size() == DEPTH));
        if (q.size() != 0) check({tag, "_head"}, 32'(bus.rd_data), 32'(q[0]));
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_frame_err"}, 32'(fe_seen), 32'(fe_exp));
        check({tag, "_overrun"}, 32'(ov_seen), 32'(ov_exp));
    endtask

    task automatic pop_one(input string tag);
        logic [7:0] exp;
        exp = q.pop_front();
        check({tag, "_empty"}, 32'(bus.empty), 32'd0);
        check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
        bus.rd_en = 1'b1;
        @(negedge HCLK);
        bus.rd_en = 1'b0;
    endtask

    // Drives one frame; when pop_on_push is set, rd_en covers exactly the stop-sample edge,
    // which lies 2 (sync) + 1 (edge detect) + B/2 + 9*B edges after the start-bit drive.
    task automatic send_frame(input logic [7:0] data, input bit stop, input bit pop_on_push,
                              input int gap);
        logic [7:0] popped;
        bus.rx = 1'b0;
        repeat (B) @(negedge HCLK);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            repeat (B) @(negedge HCLK);
        end
        bus.rx = stop;
        if (pop_on_push) begin
            repeat (2 + B / 2) @(negedge HCLK);
            check("push_pop_head", 32'(bus.rd_data), 32'(q[0]));
            bus.rd_en = 1'b1;
            @(negedge HCLK);
            bus.rd_en = 1'b0;
            repeat (B - 3 - B / 2) @(negedge HCLK);
        end else begin
            repeat (B) @(negedge HCLK);
        end
        bus.rx = 1'b1;
        repeat (gap) @(negedge HCLK);
        if (!stop) fe_exp++;
        else if (pop_on_push) begin
            popped = q.pop_front();
            q.push_back(data);
        end else if (q.size() < DEPTH) q.push_back(data);
        else ov_exp++;
    endtask

    initial begin
        logic [7:0] b;
        int         k;
        HRESETn   = 1'b0;
        bus.rx    = 1'b1;
        bus.rd_en = 1'b0;
        repeat (3) @(negedge HCLK);
        check("reset_rd_data", 32'(bus.rd_data), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);
        check_fifo("reset");
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);

        // Basic ordering
        send_frame(8'h55, 1'b1, 1'b0, 3);
        check_fifo("t1_first");
        send_frame(8'h00, 1'b1, 1'b0, 3);
        send_frame(8'hFF, 1'b1, 1'b0, 3);
        check("t1_count3", 32'(bus.count), 32'd3);
        check_fifo("t1_three");
        for (int i = 0; i < 3; i++) pop_one("t1_pop");
        check_fifo("t1_drained");
        check_pulses("t1");

        // Short low glitch is rejected at the mid-start sample
        bus.rx = 1'b0;
        repeat (4) @(negedge HCLK);
        check("t2_busy_rise", 32'(bus.busy), 32'd1);
        bus.rx = 1'b1;
        repeat (8) @(negedge HCLK);
        check("t2_busy_fall", 32'(bus.busy), 32'd0);
        check_fifo("t2");
        check_pulses("t2");

        // Bad stop bit
        send_frame(8'hA3, 1'b0, 1'b0, 4);
        check_fifo("t3");
        check_pulses("t3");

        // Overfill by one
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0, 2);
        check("t4_full", 32'(bus.full), 32'd1);
        check("t4_count16", 32'(bus.count), 32'd16);
        check_pulses("t4");
        for (int i = 0; i < 16; i++) pop_one("t4_pop");
        check_fifo("t4_drained");

        // Push and pop on the same edge while full
        for (int i = 0; i < 16; i++) send_frame(8'($urandom_range(255)), 1'b1, 1'b0, 1);
        check("t5_full_before", 32'(bus.full), 32'd1);
        send_frame(8'h77, 1'b1, 1'b1, 2);
        check("t5_count16", 32'(bus.count), 32'd16);
        check("t5_last", 32'(q[DEPTH-1]), 32'h77);
        check_pulses("t5");
        for (int i = 0; i < 16; i++) pop_one("t5_pop");
        check_fifo("t5_drained");

        // Reset in the middle of data bit 4 with bytes queued
        send_frame(8'h12, 1'b1, 1'b0, 2);
        send_frame(8'h34, 1'b1, 1'b0, 2);
        b = 8'hE9;
        bus.rx = 1'b0;
        repeat (B) @(negedge HCLK);
        for (int i = 0; i < 4; i++) begin
            bus.rx = b[i];
            repeat (B) @(negedge HCLK);
        end
        bus.rx = b[4];
        repeat (B / 2) @(negedge HCLK);
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        bus.rx  = 1'b1;
        q.delete();
        check("t6_busy", 32'(bus.busy), 32'd0);
        check_fifo("t6_reset");
        repeat (3) @(negedge HCLK);
        send_frame(8'hC3, 1'b1, 1'b0, 2);
        check_fifo("t6_after");
        pop_one("t6_pop");
        check_pulses("t6");

        // Random frames, occasional bad stop bits, random pops between frames
        for (int n = 0; n < 14; n++) begin
            b = 8'($urandom_range(255));
            send_frame(b, ($urandom_range(5) != 0), 1'b0, 1 + $urandom_range(3));
            check_fifo("rand_frame");
            k = $urandom_range(2);
            for (int i = 0; i < k; i++) if (q.size() != 0) pop_one("rand_pop");
        end
        check_pulses("rand");
        while (q.size() != 0) pop_one("rand_drain");
        check_fifo("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
